// File: rtl/id_ex_elastic_reg.sv
// ID->EX elastic pipeline boundary.
// A main entry (M) drives execute; a skid entry (S) absorbs the one extra entry that
// decode may push in the cycle execute stalls. Because in_ready is a register, a stall
// never creates a combinational path from out_ready back to in_ready.
// Control fields are kept at zero whenever their entry is not valid, so a bubble on the
// EX side always decodes as a NOP.
module id_ex_elastic_reg #(
    parameter int unsigned CTRL_W   = 10,
    parameter int unsigned DATA_W   = 120,
    parameter bit          CLR_DATA = 1'b0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;

    logic              in_ready_q;
    logic              in_ready_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [1:0]        occ_q;
    logic [1:0]        occ_d;

    logic [CTRL_W-1:0] m_ctrl_q;
    logic [DATA_W-1:0] m_data_q;
    logic [CTRL_W-1:0] s_ctrl_q;
    logic [DATA_W-1:0] s_data_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              load_m_in_s;
    logic              load_m_skid_s;
    logic              load_s_s;
    logic              clr_m_ctrl_s;
    logic              clr_s_ctrl_s;
    logic              stall_s;

    assign in_xfer_s  = in_valid & in_ready_q;
    assign out_xfer_s = out_valid_q & out_ready;
    assign stall_s    = out_valid_q & ~out_ready & ~flush;

    // State register plus the registered handshake/occupancy outputs derived from next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
        end
    end

    // Next-state logic; a flush overrides every transfer and empties the stage
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && !out_xfer_s) begin
                    state_d = ST_FULL;
                end else if (!in_xfer_s && out_xfer_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_FULL: begin
                if (out_xfer_s) begin
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_d;
        end
    end

    // Output logic: next values of the registered flags and the entry load/clear strobes
    always_comb begin
        in_ready_d    = (state_d != ST_FULL);
        out_valid_d   = (state_d != ST_EMPTY);
        load_m_in_s   = 1'b0;
        load_m_skid_s = 1'b0;
        load_s_s      = 1'b0;
        clr_m_ctrl_s  = 1'b0;
        clr_s_ctrl_s  = 1'b0;
        case (state_d)
            ST_EMPTY: occ_d = 2'd0;
            ST_ONE:   occ_d = 2'd1;
            ST_FULL:  occ_d = 2'd2;
            default:  occ_d = 2'd0;
        endcase
        case (state_q)
            ST_EMPTY: begin
                load_m_in_s = in_xfer_s;
            end
            ST_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    load_m_in_s = 1'b1;
                end else if (in_xfer_s) begin
                    load_s_s = 1'b1;
                end else if (out_xfer_s) begin
                    clr_m_ctrl_s = 1'b1;
                end else begin
                    load_m_in_s = 1'b0;
                end
            end
            ST_FULL: begin
                if (out_xfer_s) begin
                    load_m_skid_s = 1'b1;
                    clr_s_ctrl_s  = 1'b1;
                end else begin
                    load_m_skid_s = 1'b0;
                end
            end
            default: begin
                load_m_in_s = 1'b0;
            end
        endcase
    end

    // Entry storage: M feeds execute, S holds the spilled entry; invalid ctrl is kept at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ctrl_q <= {CTRL_W{1'b0}};
            m_data_q <= {DATA_W{1'b0}};
            s_ctrl_q <= {CTRL_W{1'b0}};
            s_data_q <= {DATA_W{1'b0}};
        end else if (flush) begin
            m_ctrl_q <= {CTRL_W{1'b0}};
            s_ctrl_q <= {CTRL_W{1'b0}};
            if (CLR_DATA) begin
                m_data_q <= {DATA_W{1'b0}};
                s_data_q <= {DATA_W{1'b0}};
            end
        end else begin
            if (load_m_in_s) begin
                m_ctrl_q <= in_ctrl;
                m_data_q <= in_data;
            end else if (load_m_skid_s) begin
                m_ctrl_q <= s_ctrl_q;
                m_data_q <= s_data_q;
            end else if (clr_m_ctrl_s) begin
                m_ctrl_q <= {CTRL_W{1'b0}};
            end
            if (load_s_s) begin
                s_ctrl_q <= in_ctrl;
                s_data_q <= in_data;
            end else if (clr_s_ctrl_s) begin
                s_ctrl_q <= {CTRL_W{1'b0}};
            end
        end
    end

    // Saturating stall profiler; only rst clears it, flush cycles are not counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = m_ctrl_q;
    assign out_data  = m_data_q;
    assign occupancy = occ_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Bench for id_ex_elastic_reg: three instances share one stimulus stream
// (A: defaults, B: CLR_DATA=1, C: CNT_W=4) and are compared against a queue model.
module tb_id_ex_elastic_reg;

    localparam int CW = 10;
    localparam int DW = 120;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          a_ready, a_valid, b_ready, b_valid, c_ready, c_valid;
    logic [CW-1:0] a_ctrl, b_ctrl, c_ctrl;
    logic [DW-1:0] a_data, b_data, c_data;
    logic [1:0]    a_occ, b_occ, c_occ;
    logic [15:0]   a_stall, b_stall;
    logic [3:0]    c_stall;

    id_ex_elastic_reg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_valid), .out_ready(out_ready),
        .out_ctrl(a_ctrl), .out_data(a_data), .occupancy(a_occ), .stall_cnt(a_stall));

    id_ex_elastic_reg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_valid), .out_ready(out_ready),
        .out_ctrl(b_ctrl), .out_data(b_data), .occupancy(b_occ), .stall_cnt(b_stall));

    id_ex_elastic_reg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b0), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_valid), .out_ready(out_ready),
        .out_ctrl(c_ctrl), .out_data(c_data), .occupancy(c_occ), .stall_cnt(c_stall));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    int   exp_stall;
    int   n_cmp;
    int   n_fail;

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) d = {d[DW-33:0], 32'($urandom())};
        return d;
    endfunction

    function automatic logic [CW-1:0] exp_ctrl();
        return (mq.size() != 0) ? mq[0].c : '0;
    endfunction

    function automatic logic [15:0] exp_s16();
        return (exp_stall > 65535) ? 16'hFFFF : 16'(exp_stall);
    endfunction

    function automatic logic [3:0] exp_s4();
        return (exp_stall > 15) ? 4'hF : 4'(exp_stall);
    endfunction

    // One clock: model applies FIFO rules to the values presented before the edge
    task automatic tick();
        bit   in_x, out_x, st;
        ent_t e;
        in_x  = in_valid && (mq.size() < 2);
        out_x = out_ready && (mq.size() > 0);
        st    = (mq.size() > 0) && !out_ready && !flush;
        e.c   = in_ctrl;
        e.d   = in_data;
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (out_x) void'(mq.pop_front());
            if (in_x) mq.push_back(e);
        end
        if (st) exp_stall++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        @(posedge clk); #2;
        mq.delete(); exp_stall = 0;
        n_cmp++;
        if (a_valid !== 1'b0 || a_ready !== 1'b1 || a_occ !== 2'd0 || a_ctrl !== '0 || a_stall !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_a: valid=%b ready=%b occ=%0d ctrl=%h stall=%0d, want 0 1 0 0 0",
                     a_valid, a_ready, a_occ, a_ctrl, a_stall);
        end
        n_cmp++;
        if (a_data !== '0 || b_data !== '0 || c_data !== '0 || c_stall !== 4'd0 || b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: a=%h b=%h c=%h cst=%0d bval=%b, want all 0", a_data, b_data, c_data, c_stall, b_valid);
        end
        rst = 1'b0;
        tick(); tick();
        n_cmp++;
        if (a_valid !== 1'b0 || a_ready !== 1'b1 || a_occ !== 2'd0 || a_ctrl !== '0 || a_stall !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_idle: valid=%b ready=%b occ=%0d ctrl=%h stall=%0d, want 0 1 0 0 0",
                     a_valid, a_ready, a_occ, a_ctrl, a_stall);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = DW'(i);
            in_ctrl = CW'($urandom_range(1023, 1));
            tick();
            n_cmp++;
            if (a_valid !== 1'b1 || a_ready !== 1'b1 || a_data !== DW'(i) || a_ctrl !== exp_ctrl()) begin
                n_fail++;
                $display("FAIL stream[%0d]: valid=%b ready=%b data=%0h ctrl=%h, want 1 1 %0h %h",
                         i, a_valid, a_ready, a_data, a_ctrl, i, exp_ctrl());
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (a_valid !== 1'b0 || a_ctrl !== '0 || a_occ !== 2'd0) begin
            n_fail++;
            $display("FAIL stream_drain: valid=%b ctrl=%h occ=%0d, want 0 0 0", a_valid, a_ctrl, a_occ);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] da, db;
        int            base;
        da = rand_data(); db = rand_data();
        base = exp_stall;
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = da; in_ctrl = CW'($urandom_range(1023, 1));
        tick();
        in_data = db; in_ctrl = CW'($urandom_range(1023, 1));
        tick();
        n_cmp++;
        if (a_occ !== 2'd2 || a_ready !== 1'b0 || a_data !== da || a_ctrl !== exp_ctrl()) begin
            n_fail++;
            $display("FAIL bp_full: occ=%0d ready=%b data=%h, want 2 0 %h", a_occ, a_ready, a_data, da);
        end
        in_data = rand_data();
        tick(); tick();
        in_valid = 1'b0;
        n_cmp++;
        if (a_occ !== 2'd2 || a_data !== da || a_stall !== 16'(base + 3)) begin
            n_fail++;
            $display("FAIL bp_hold: occ=%0d data=%h stall=%0d, want 2 %h %0d", a_occ, a_data, a_stall, da, base + 3);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (a_valid !== 1'b1 || a_data !== db || a_occ !== 2'd1 || a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: valid=%b data=%h occ=%0d ready=%b, want 1 %h 1 1", a_valid, a_data, a_occ, a_ready, db);
        end
        tick();
        n_cmp++;
        if (a_valid !== 1'b0 || a_ctrl !== '0 || a_stall !== exp_s16()) begin
            n_fail++;
            $display("FAIL bp_empty: valid=%b ctrl=%h stall=%0d, want 0 0 %0d", a_valid, a_ctrl, a_stall, exp_s16());
        end
    endtask

    task automatic test_flush();
        logic [15:0] st_before;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = rand_data(); in_ctrl = CW'($urandom_range(1023, 1));
            tick();
        end
        in_data = DW'(120'hC0C0C); in_ctrl = CW'($urandom_range(1023, 1));
        flush = 1'b1;
        st_before = a_stall;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (a_valid !== 1'b0 || a_ctrl !== '0 || a_occ !== 2'd0 || a_ready !== 1'b1 || a_stall !== st_before) begin
            n_fail++;
            $display("FAIL flush_full: valid=%b ctrl=%h occ=%0d ready=%b stall=%0d, want 0 0 0 1 %0d",
                     a_valid, a_ctrl, a_occ, a_ready, a_stall, st_before);
        end
        out_ready = 1'b1;
        tick(); tick();
        n_cmp++;
        if (a_valid !== 1'b0 || a_occ !== 2'd0 || b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_c: valid=%b occ=%0d bvalid=%b, want 0 0 0", a_valid, a_occ, b_valid);
        end
    endtask

    task automatic test_clr_data();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = DW'(120'hABC); in_ctrl = CW'($urandom_range(1023, 1));
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (a_valid !== 1'b0 || a_data !== DW'(120'hABC)) begin
            n_fail++;
            $display("FAIL clr0_data: valid=%b data=%h, want 0 abc", a_valid, a_data);
        end
        n_cmp++;
        if (b_valid !== 1'b0 || b_data !== '0 || b_ctrl !== '0) begin
            n_fail++;
            $display("FAIL clr1_data: valid=%b data=%h ctrl=%h, want 0 0 0", b_valid, b_data, b_ctrl);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(9, 0) < 7);
            out_ready = ($urandom_range(9, 0) < 6);
            flush     = ($urandom_range(19, 0) == 0);
            in_ctrl   = CW'($urandom_range(1023, 1));
            in_data   = rand_data();
            tick();
            n_cmp++;
            if (a_valid !== (mq.size() != 0) || a_ready !== (mq.size() != 2) || a_occ !== 2'(mq.size())) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: valid=%b ready=%b occ=%0d, want occ %0d", cyc, a_valid, a_ready, a_occ, mq.size());
            end
            n_cmp++;
            if (a_ctrl !== exp_ctrl() || b_ctrl !== exp_ctrl() || a_stall !== exp_s16() || c_stall !== exp_s4()) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: ctrl=%h stall=%0d cstall=%0d, want %h %0d %0d",
                         cyc, a_ctrl, a_stall, c_stall, exp_ctrl(), exp_s16(), exp_s4());
            end
            if (mq.size() != 0) begin
                n_cmp++;
                if (a_data !== mq[0].d || b_data !== mq[0].d) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: a=%h b=%h, want %h", cyc, a_data, b_data, mq[0].d);
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_stall_sat();
        rst = 1'b1; #2; rst = 1'b0;
        mq.delete(); exp_stall = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = rand_data(); in_ctrl = CW'($urandom_range(1023, 1));
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (c_stall !== 4'd15 || a_stall !== 16'd20) begin
            n_fail++;
            $display("FAIL stall_sat: c=%0d a=%0d, want 15 20", c_stall, a_stall);
        end
        tick(); tick();
        n_cmp++;
        if (c_stall !== 4'd15 || c_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: c=%0d valid=%b, want 15 1", c_stall, c_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (c_stall !== 4'd0 || c_valid !== 1'b0 || a_valid !== 1'b0 || a_occ !== 2'd0 || a_stall !== 16'd0 || a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst: cst=%0d cval=%b aval=%b occ=%0d ast=%0d rdy=%b, want 0 0 0 0 0 1",
                     c_stall, c_valid, a_valid, a_occ, a_stall, a_ready);
        end
        #2 rst = 1'b0;
        mq.delete(); exp_stall = 0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; exp_stall = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_clr_data();
        test_random();
        test_stall_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
